// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier result accumulator.
//   acc_state_t : accumulator FSM states (ACC = summing, OUT = sum presented)
//   acc_width() : accumulator width that cannot overflow for n full-scale products
//   cnt_width() : width of a counter that must reach n
package mul_pkg;

  typedef enum logic [0:0] {
    ACC,
    OUT
  } acc_state_t;

  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned acc_num);
    return 2 * data_width + $clog2(acc_num);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned acc_num);
    return $clog2(acc_num + 1);
  endfunction

  localparam int unsigned DefAccNum = 4;
  localparam int unsigned DefCntWidth = cnt_width(DefAccNum);

endpackage

// File: rtl/mul_res_edge_det.sv
// Rising-edge detector for the multiplier's end level.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (registered level clears to 0)
//   i_level : level input
//   o_rise  : high while i_level is high and was low on the previous clock
module mul_res_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic level_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= i_level;
    end
  end

  // Registered level resets to 0, so a level already high after reset counts once.
  assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/mul_res_acc.sv
// Multiplier result accumulator.
// Captures the product on each rising edge of the multiplier end flag, sums ACC_NUM
// consecutive products and presents the sum on a valid/ready port. A one-entry
// pending buffer absorbs one product arriving while the output is stalled; a
// further product in that state is dropped and flagged.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_end, i_res   : multiplier done level and product
//   i_clr          : synchronous clear of all accumulation state
//   i_ready        : downstream accepts o_acc
//   o_valid, o_acc : completed sum and its qualifier
//   o_cnt          : products in the current accumulation
//   o_drop         : one-cycle pulse when a product is lost
module mul_res_acc
  import mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ACC_NUM    = 4,  // must be >= 2
  parameter int unsigned GUARD_BITS = acc_width(DATA_WIDTH, ACC_NUM) - 2 * DATA_WIDTH
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_end,
  input  logic [2*DATA_WIDTH-1:0]            i_res,
  input  logic                               i_clr,
  input  logic                               i_ready,
  output logic                               o_valid,
  output logic [2*DATA_WIDTH+GUARD_BITS-1:0] o_acc,
  output logic [$clog2(ACC_NUM+1)-1:0]       o_cnt,
  output logic                               o_drop
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned AW = PW + GUARD_BITS;
  localparam int unsigned CW = cnt_width(ACC_NUM);
  localparam logic [CW-1:0] CntLast = CW'(ACC_NUM - 1);

  acc_state_t    state_q;
  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] pend_q;
  logic          pend_full_q;
  logic          valid_q;
  logic          drop_q;
  logic          rise;

  mul_res_edge_det u_edge_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_level (i_end),
    .o_rise  (rise)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (i_clr) begin
        // Clear wins over any simultaneous rise and withdraws an unaccepted sum.
        state_q     <= ACC;
        acc_q       <= '0;
        cnt_q       <= '0;
        pend_q      <= '0;
        pend_full_q <= 1'b0;
        valid_q     <= 1'b0;
      end else begin
        unique case (state_q)
          ACC: begin
            if (rise) begin
              acc_q <= acc_q + AW'(i_res);
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == CntLast) begin
                state_q <= OUT;
                valid_q <= 1'b1;
              end
            end
          end
          OUT: begin
            if (i_ready) begin
              // Handshake: restart from the pending product (if any) plus a
              // product rising in this very cycle.
              pend_full_q <= 1'b0;
              state_q     <= ACC;
              valid_q     <= 1'b0;
              if (pend_full_q) begin
                if (rise) begin
                  acc_q <= AW'(pend_q) + AW'(i_res);
                  cnt_q <= CW'(2);
                  if (ACC_NUM == 2) begin
                    state_q <= OUT;
                    valid_q <= 1'b1;
                  end
                end else begin
                  acc_q <= AW'(pend_q);
                  cnt_q <= CW'(1);
                end
              end else begin
                if (rise) begin
                  acc_q <= AW'(i_res);
                  cnt_q <= CW'(1);
                end else begin
                  acc_q <= '0;
                  cnt_q <= '0;
                end
              end
            end else if (rise) begin
              if (pend_full_q) begin
                drop_q <= 1'b1;
              end else begin
                pend_q      <= i_res;
                pend_full_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ACC;
          end
        endcase
      end
    end
  end

  assign o_valid = valid_q;
  assign o_acc   = acc_q;
  assign o_cnt   = cnt_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_mul_res_acc.sv
module tb_mul_res_acc;

  localparam int unsigned DW = 4;
  localparam int unsigned N  = 4;

  logic       clk;
  logic       rst_n;
  logic       i_end;
  logic [7:0] i_res;
  logic       i_clr;
  logic       i_ready;
  logic       o_valid;
  logic [9:0] o_acc;
  logic [2:0] o_cnt;
  logic       o_drop;

  mul_res_acc #(
    .DATA_WIDTH (DW),
    .ACC_NUM    (N)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_end   (i_end),
    .i_res   (i_res),
    .i_clr   (i_clr),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_acc   (o_acc),
    .o_cnt   (o_cnt),
    .o_drop  (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: products in the running group, at most one held product,
  // the sum on offer, and a queue of sums the consumer should receive in order.
  int unsigned cur[$];
  int unsigned held[$];
  int unsigned sbq[$];
  bit          busy = 0;
  int unsigned out_sum = 0;
  bit          prev_end = 0;

  // Expected DUT outputs after the next clock edge.
  int unsigned exp_acc = 0;
  int unsigned exp_cnt = 0;
  bit          exp_valid = 0;
  bit          exp_drop = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned group_sum();
    int unsigned s = 0;
    foreach (cur[k]) s += cur[k];
    return s;
  endfunction

  task automatic model_reset();
    cur.delete();
    held.delete();
    sbq.delete();
    busy = 0;
    out_sum = 0;
    prev_end = 0;
    exp_acc = 0;
    exp_cnt = 0;
    exp_valid = 0;
    exp_drop = 0;
  endtask

  task automatic model_edge(input bit e, input int unsigned r, input bit c, input bit rdy);
    bit rise;
    bit drop;
    rise = e && !prev_end;
    prev_end = e;
    drop = 0;
    if (c) begin
      if (busy) void'(sbq.pop_back());
      cur.delete();
      held.delete();
      busy = 0;
    end else begin
      if (busy && rdy) begin
        busy = 0;
        cur = held;
        held.delete();
      end
      if (rise) begin
        if (busy) begin
          if (held.size() == 0) held.push_back(r);
          else drop = 1;
        end else begin
          cur.push_back(r);
        end
      end
      if (!busy && cur.size() == N) begin
        busy = 1;
        out_sum = group_sum();
        sbq.push_back(out_sum);
        cur.delete();
      end
    end
    exp_drop  = drop;
    exp_valid = busy;
    exp_cnt   = busy ? N : cur.size();
    exp_acc   = busy ? out_sum : group_sum();
  endtask

  // Drive inputs for the coming edge and advance the model to match.
  task automatic step(input bit e, input int unsigned r, input bit c, input bit rdy);
    @(posedge clk);
    #2;
    i_end = e;
    i_res = r[7:0];
    i_clr = c;
    i_ready = rdy;
    model_edge(e, r, c, rdy);
  endtask

  task automatic pulse(input int unsigned r, input bit rdy);
    step(1, r, 0, rdy);
    step(0, 0, 0, rdy);
  endtask

  // Per-cycle state check just after each edge.
  always @(posedge clk) begin
    #1;
    chk("valid", o_valid, exp_valid);
    chk("acc", o_acc, exp_acc);
    chk("cnt", o_cnt, exp_cnt);
    chk("drop", o_drop, exp_drop);
  end

  // Scoreboard: every accepted sum must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready && !i_clr) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_sum", o_acc, 1024);
      end else begin
        chk("sb_sum", o_acc, sbq.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_end = 1'b0;
    i_res = '0;
    i_clr = 1'b0;
    i_ready = 1'b1;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_acc", o_acc, 0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_drop", o_drop, 0);
    #12 rst_n = 1'b1;

    // Sequential products
    pulse(90, 1);
    pulse(50, 1);
    pulse(9, 1);
    step(1, 225, 0, 1);
    step(0, 0, 0, 1);
    chk("seq_valid", o_valid, 1);
    chk("seq_acc374", o_acc, 374);
    chk("seq_cnt4", o_cnt, 4);
    step(0, 0, 0, 1);
    chk("seq_after_acc", o_acc, 0);
    chk("seq_after_cnt", o_cnt, 0);

    // Level hold counts once
    for (int k = 0; k < 10; k++) step(1, 50, 0, 1);
    step(0, 0, 0, 1);
    chk("hold_cnt1", o_cnt, 1);
    chk("hold_acc50", o_acc, 50);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // Stall with pending
    pulse(90, 0);
    pulse(50, 0);
    pulse(9, 0);
    pulse(225, 0);
    chk("stall_acc374", o_acc, 374);
    step(1, 90, 0, 0);
    step(0, 0, 0, 0);
    chk("stall_hold374", o_acc, 374);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("pend_cnt1", o_cnt, 1);
    chk("pend_acc90", o_acc, 90);

    // Drop on double stall
    pulse(50, 0);
    pulse(9, 0);
    pulse(225, 0);
    chk("drop_pre_valid", o_valid, 1);
    step(1, 90, 0, 0);
    step(0, 0, 0, 0);
    step(1, 9, 0, 0);
    step(0, 0, 0, 0);
    chk("drop_pulse", o_drop, 1);
    step(0, 0, 0, 0);
    chk("drop_one_cycle", o_drop, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("drop_excl_acc90", o_acc, 90);
    chk("drop_excl_cnt1", o_cnt, 1);

    // Clear during output
    pulse(50, 0);
    pulse(9, 0);
    pulse(225, 0);
    chk("clr_pre_acc374", o_acc, 374);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("clr_valid", o_valid, 0);
    chk("clr_acc", o_acc, 0);
    chk("clr_cnt", o_cnt, 0);

    // Async reset mid-accumulation
    pulse(90, 1);
    pulse(50, 1);
    #1;
    chk("arst_pre_cnt2", o_cnt, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_acc", o_acc, 0);
    chk("arst_cnt", o_cnt, 0);
    chk("arst_drop", o_drop, 0);
    model_reset();
    #1 rst_n = 1'b1;
    step(1, 225, 0, 1);
    step(0, 0, 0, 1);
    chk("arst_post_cnt1", o_cnt, 1);
    chk("arst_post_acc225", o_acc, 225);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 255),
           $urandom_range(0, 80) == 0, $urandom_range(0, 3) != 0);
    end
    // Flush: finish any stalled sum, then clear the partial group.
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
